de0_step_clock_gen: RTL and testbench
=====================================

Name: de0_step_clock_gen

Overview:
- Generates the slow datapath clock for the DE0 datapath test harness from the 50 MHz board clock.
- Provides two clock sources:
  - single-step: one clean clock pulse per debounced press of an active-low push button;
  - auto-run: a free-running clock at a selectable division rate.
- Sits directly upstream of the datapath: its dp_clock output drives the datapath clock input.
- Also exports a step counter and a rising-edge strobe for display and logic logging.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable CLOCK_50 cycles required to accept a new button level (10 ms).
- PULSE_CYCLES, 4: cycles dp_clock stays high for a single step; also the minimum low time after each step.
- BASE_DIV, 25000: auto-run half-period unit, in CLOCK_50 cycles.

Ports:
- clock, input, 1: board clock (CLOCK_50); all logic is on its rising edge.
- reset, input, 1: asynchronous, active-low; reset is asserted while 0.
- step_btn_n, input, 1: raw push button, active-low, asynchronous and bouncy.
- run_mode, input, 1: slide switch; 1 selects auto-run. Asynchronous.
- div_sel, input, 4: auto-run rate; half-period = BASE_DIV << div_sel.
- dp_clock, output, 1: registered datapath clock.
- dp_clock_rise, output, 1: one-cycle strobe, high in the same cycle dp_clock goes 0 to 1.
- cycle_count, output, 16: number of dp_clock rising edges since reset; wraps.
- busy, output, 1: high while a single-step pulse, or its low guard time, is in progress.

Behaviour:
- Reset (reset=0): immediately and asynchronously:
  - dp_clock=0, dp_clock_rise=0, cycle_count=0, busy=0;
  - FSM goes to IDLE;
  - synchronizers and debounced button level are set to 1 (released);
  - all counters are cleared.
- Synchronization: step_btn_n and run_mode each pass through a 2-flop synchronizer.
- Debounce:
  - The counter increments while the synchronized button differs from the debounced level, and clears on any cycle where they agree.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level takes the new value and the counter clears.
- Press event: a debounced 1-to-0 transition. Release events are ignored.
- Latency: dp_clock rises exactly DEBOUNCE_CYCLES+3 CLOCK_50 cycles after a clean falling edge on step_btn_n.
- FSM states: IDLE, STEP_HI, STEP_LO, RUN_HI, RUN_LO.
  - IDLE: dp_clock=0.
    - If run_mode (synchronized) =1: go to RUN_HI.
    - Else, on a press: go to STEP_HI.
    - run_mode has priority over a simultaneous press, and that press is discarded.
  - STEP_HI: dp_clock=1 and busy=1 for PULSE_CYCLES cycles, then go to STEP_LO.
  - STEP_LO: dp_clock=0 and busy=1 for PULSE_CYCLES cycles, then go to IDLE.
  - During STEP_HI and STEP_LO, presses are dropped (not queued) and run_mode is not acted on until IDLE.
  - RUN_HI: dp_clock=1 for BASE_DIV<<div_sel cycles.
  - RUN_LO: dp_clock=0 for BASE_DIV<<div_sel cycles.
  - div_sel is sampled at entry to each RUN phase; changes mid-phase take effect at the next phase.
  - Leaving run mode: if run_mode=0 at the end of RUN_LO, go to IDLE. If run_mode drops during RUN_HI, the high phase completes, then RUN_LO completes, then the FSM goes to IDLE. The datapath never sees a short high pulse.
  - Presses are ignored in RUN states.
- Phase counter: 20 bits.
- cycle_count: increments by 1 on every dp_clock 0-to-1 transition and wraps from 0xFFFF to 0x0000.
- dp_clock_rise and the cycle_count update occur in the same cycle as the dp_clock rise.
- Button held through reset release: the debounced level starts as released, so a held button produces exactly one press DEBOUNCE_CYCLES+2 cycles after reset deasserts.
- Reset mid-pulse or mid-run: dp_clock drops to 0 asynchronously. No press is replayed after reset.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=8, PULSE_CYCLES=4, BASE_DIV=3.
1. Hold reset=0 for 5 cycles with the button pressed, then release reset. Required: all outputs 0 during reset; one step pulse follows reset release; cycle_count=1.
2. Clean press held for 40 cycles. Required: dp_clock rises 11 cycles after the button edge and stays high exactly 4 cycles; dp_clock_rise is high for 1 cycle; busy is high for 8 cycles; cycle_count=1; no second pulse.
3. Bounce: button toggles every 3 cycles for 30 cycles, then stays low. Required: exactly one pulse, cycle_count increments by 1.
4. Second press debounced during STEP_LO. Required: dropped; cycle_count stays 1; a further press after IDLE gives cycle_count=2.
5. run_mode=1, div_sel=1. Required: dp_clock has a 12-cycle period with 6 high and 6 low; after 10 rises cycle_count=10. Then drop run_mode mid-high. Required: the high phase still lasts 6 cycles, the low phase lasts 6 cycles, the FSM returns to IDLE, and cycle_count stays 10.
6. BASE_DIV=1, div_sel=0, run for 65537 rises. Required: cycle_count wraps to 0x0001. Then assert reset during dp_clock=1. Required: dp_clock=0 in the same cycle and cycle_count=0.

Source files
------------

// File: rtl/de0_step_clock_gen.sv
// Slow datapath clock for the DE0 harness: one clean pulse per debounced button
// press, or a free-running clock whose half-period is BASE_DIV << div_sel.
module de0_step_clock_gen #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PULSE_CYCLES    = 4,
  parameter int BASE_DIV        = 25000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        step_btn_n,
  input  logic        run_mode,
  input  logic [3:0]  div_sel,
  output logic        dp_clock,
  output logic        dp_clock_rise,
  output logic [15:0] cycle_count,
  output logic        busy
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [19:0]    PULSE_LOAD = 20'(PULSE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, STEP_HI, STEP_LO, RUN_HI, RUN_LO} state_t;

  state_t           state, state_nx;
  logic [19:0]      phase, phase_nx;
  logic [1:0]       btn_sync, run_sync;
  logic             btn_s, run_s;
  logic             btn_db, press;
  logic [DBW-1:0]   db_cnt;
  logic [35:0]      run_len;
  logic [19:0]      run_load;
  logic             clk_nx, rise_nx;

  assign btn_s = btn_sync[1];
  assign run_s = run_sync[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_sync <= 2'b11;
      run_sync <= 2'b00;
    end else begin
      btn_sync <= {btn_sync[0], step_btn_n};
      run_sync <= {run_sync[0], run_mode};
    end
  end

  // press is registered on the same edge the debounced level falls
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      db_cnt <= '0;
      btn_db <= 1'b1;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (btn_s == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt <= '0;
        btn_db <= btn_s;
        press  <= btn_db;
      end else begin
        db_cnt <= db_cnt + DBW'(1);
      end
    end
  end

  // Half-periods too long for the 20-bit phase counter saturate at its maximum.
  assign run_len  = 36'(BASE_DIV) << div_sel;
  assign run_load = (run_len > 36'h100000) ? 20'hFFFFF : 20'(run_len - 36'd1);

  always_comb begin
    state_nx = state;
    phase_nx = phase;
    unique case (state)
      IDLE: begin
        if (run_s) begin
          state_nx = RUN_HI;
          phase_nx = run_load;
        end else if (press) begin
          state_nx = STEP_HI;
          phase_nx = PULSE_LOAD;
        end
      end
      STEP_HI: begin
        if (phase == '0) begin
          state_nx = STEP_LO;
          phase_nx = PULSE_LOAD;
        end else phase_nx = phase - 20'd1;
      end
      STEP_LO: begin
        if (phase == '0) state_nx = IDLE;
        else             phase_nx = phase - 20'd1;
      end
      RUN_HI: begin
        if (phase == '0) begin
          state_nx = RUN_LO;
          phase_nx = run_load;
        end else phase_nx = phase - 20'd1;
      end
      RUN_LO: begin
        if (phase == '0) begin
          if (run_s) begin
            state_nx = RUN_HI;
            phase_nx = run_load;
          end else state_nx = IDLE;
        end else phase_nx = phase - 20'd1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so dp_clock is glitch-free.
  assign clk_nx  = (state_nx == STEP_HI) || (state_nx == RUN_HI);
  assign rise_nx = clk_nx & ~dp_clock;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      phase         <= '0;
      dp_clock      <= 1'b0;
      dp_clock_rise <= 1'b0;
      cycle_count   <= '0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nx;
      phase         <= phase_nx;
      dp_clock      <= clk_nx;
      dp_clock_rise <= rise_nx;
      cycle_count   <= cycle_count + {15'd0, rise_nx};
      busy          <= (state_nx == STEP_HI) || (state_nx == STEP_LO);
    end
  end

endmodule

// File: tb/tb_de0_step_clock_gen.sv
// Directed bench: dut_a uses the nominal small parameters, dut_b has a long
// pulse (so a press can land in the guard time) and a 1-cycle run half-period.
module tb_de0_step_clock_gen;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        a_reset, a_btn, a_run, a_dpc, a_rise, a_busy;
  logic [3:0]  a_div;
  logic [15:0] a_cnt;
  logic        b_reset, b_btn, b_run, b_dpc, b_rise, b_busy;
  logic [3:0]  b_div;
  logic [15:0] b_cnt;

  int errors = 0;
  int checks = 0;

  de0_step_clock_gen #(.DEBOUNCE_CYCLES(8), .PULSE_CYCLES(4), .BASE_DIV(3)) dut_a (
    .clock(clock), .reset(a_reset), .step_btn_n(a_btn), .run_mode(a_run), .div_sel(a_div),
    .dp_clock(a_dpc), .dp_clock_rise(a_rise), .cycle_count(a_cnt), .busy(a_busy));

  de0_step_clock_gen #(.DEBOUNCE_CYCLES(8), .PULSE_CYCLES(20), .BASE_DIV(1)) dut_b (
    .clock(clock), .reset(b_reset), .step_btn_n(b_btn), .run_mode(b_run), .div_sel(b_div),
    .dp_clock(b_dpc), .dp_clock_rise(b_rise), .cycle_count(b_cnt), .busy(b_busy));

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic reset_a;
    a_reset = 1'b0; a_btn = 1'b1; a_run = 1'b0; a_div = 4'd0;
    repeat (3) tick;
    a_reset = 1'b1;
    repeat (3) tick;
  endtask

  task automatic reset_b;
    b_reset = 1'b0; b_btn = 1'b1; b_run = 1'b0; b_div = 4'd0;
    repeat (3) tick;
    b_reset = 1'b1;
    repeat (3) tick;
  endtask

  // Button held through reset: one pulse, rising 11 cycles after release.
  task automatic test_reset;
    int first_rise, rises;
    a_reset = 1'b0; a_btn = 1'b0; a_run = 1'b0; a_div = 4'd0;
    repeat (5) begin
      tick;
      checks++;
      if ({a_dpc, a_rise, a_busy, a_cnt} !== 19'd0) begin
        errors++;
        $display("FAIL reset_outputs: dpc=%b rise=%b busy=%b cnt=%0d, want all 0",
                 a_dpc, a_rise, a_busy, a_cnt);
      end
    end
    a_reset = 1'b1;
    first_rise = -1; rises = 0;
    for (int s = 1; s <= 40; s++) begin
      tick;
      if (a_rise === 1'b1) begin
        rises++;
        if (first_rise < 0) first_rise = s;
      end
    end
    checks++;
    if (first_rise != 11) begin
      errors++; $display("FAIL held_reset_latency: rise at %0d, want 11", first_rise);
    end
    checks++;
    if (rises != 1 || a_cnt !== 16'd1) begin
      errors++; $display("FAIL held_reset_count: rises=%0d cnt=%0d, want 1/1", rises, a_cnt);
    end
    a_btn = 1'b1;
    repeat (20) tick;
    checks++;
    if (a_cnt !== 16'd1 || a_busy !== 1'b0) begin
      errors++; $display("FAIL release_ignored: cnt=%0d busy=%b, want 1/0", a_cnt, a_busy);
    end
  endtask

  task automatic test_single_step;
    int first_rise, rises, hi, bz;
    reset_a;
    a_btn = 1'b0;
    first_rise = -1; rises = 0; hi = 0; bz = 0;
    for (int s = 1; s <= 40; s++) begin
      tick;
      if (a_rise === 1'b1) begin
        rises++;
        if (first_rise < 0) first_rise = s;
      end
      if (a_dpc === 1'b1) hi++;
      if (a_busy === 1'b1) bz++;
    end
    checks++;
    if (first_rise != 11) begin
      errors++; $display("FAIL step_latency: rise at %0d, want 11", first_rise);
    end
    checks++;
    if (hi != 4) begin
      errors++; $display("FAIL step_high_len: %0d cycles, want 4", hi);
    end
    checks++;
    if (rises != 1) begin
      errors++; $display("FAIL step_rise_strobes: %0d, want 1", rises);
    end
    checks++;
    if (bz != 8) begin
      errors++; $display("FAIL step_busy_len: %0d cycles, want 8", bz);
    end
    checks++;
    if (a_cnt !== 16'd1) begin
      errors++; $display("FAIL step_count: %0d, want 1", a_cnt);
    end
    a_btn = 1'b1;
    repeat (20) tick;
  endtask

  task automatic test_bounce;
    int rises;
    reset_a;
    rises = 0;
    for (int t = 0; t < 80; t++) begin
      if (t < 30) a_btn = ((t / 3) % 2 == 0) ? 1'b0 : 1'b1;
      else        a_btn = 1'b0;
      tick;
      if (a_rise === 1'b1) rises++;
    end
    checks++;
    if (rises != 1 || a_cnt !== 16'd1) begin
      errors++; $display("FAIL bounce_one_pulse: rises=%0d cnt=%0d, want 1/1", rises, a_cnt);
    end
    a_btn = 1'b1;
    repeat (20) tick;
  endtask

  // dut_b: pulse high t=11..30, guard t=31..50; second press debounces at t=34.
  task automatic test_press_dropped;
    int rises, s;
    reset_b;
    rises = 0;
    for (int t = 0; t < 90; t++) begin
      case (t)
        0:  b_btn = 1'b0;
        12: b_btn = 1'b1;
        24: b_btn = 1'b0;
        36: b_btn = 1'b1;
        60: b_btn = 1'b0;
        default: ;
      endcase
      tick;
      s = t + 1;
      if (b_rise === 1'b1) rises++;
      if (s == 34) begin
        checks++;
        if (b_busy !== 1'b1 || b_dpc !== 1'b0) begin
          errors++; $display("FAIL guard_state: busy=%b dpc=%b, want 1/0", b_busy, b_dpc);
        end
      end
      if (s == 59) begin
        checks++;
        if (rises != 1 || b_cnt !== 16'd1) begin
          errors++; $display("FAIL press_dropped: rises=%0d cnt=%0d, want 1/1", rises, b_cnt);
        end
      end
    end
    checks++;
    if (rises != 2 || b_cnt !== 16'd2) begin
      errors++; $display("FAIL press_after_idle: rises=%0d cnt=%0d, want 2/2", rises, b_cnt);
    end
    b_btn = 1'b1;
  endtask

  // div_sel=1 -> 6 high / 6 low from t=3; run_mode dropped at t=113 (mid-high).
  task automatic test_run;
    logic exp_clk, exp_rise;
    int s;
    reset_a;
    a_div = 4'd1;
    for (int t = 0; t <= 140; t++) begin
      if (t == 0)   a_run = 1'b1;
      if (t == 113) a_run = 1'b0;
      tick;
      s = t + 1;
      exp_clk  = (s >= 3) && (s <= 116) && (((s - 3) % 12) < 6);
      exp_rise = (s >= 3) && (s <= 116) && (((s - 3) % 12) == 0);
      checks++;
      if (a_dpc !== exp_clk || a_rise !== exp_rise) begin
        errors++;
        $display("FAIL run_wave t=%0d: dpc=%b rise=%b, want %b/%b", s, a_dpc, a_rise, exp_clk, exp_rise);
      end
      if (s == 111) begin
        checks++;
        if (a_cnt !== 16'd10) begin
          errors++; $display("FAIL run_count10: %0d, want 10", a_cnt);
        end
      end
    end
    checks++;
    if (a_cnt !== 16'd10 || a_busy !== 1'b0) begin
      errors++; $display("FAIL run_exit: cnt=%0d busy=%b, want 10/0", a_cnt, a_busy);
    end
  endtask

  task automatic test_wrap_and_reset;
    int rises, guard;
    reset_b;
    b_div = 4'd0;
    b_run = 1'b1;
    rises = 0; guard = 0;
    while (rises < 65537 && guard < 140000) begin
      tick;
      guard++;
      if (b_rise === 1'b1) rises++;
    end
    checks++;
    if (rises != 65537) begin
      errors++; $display("FAIL wrap_timeout: rises=%0d, want 65537", rises);
    end
    checks++;
    if (b_cnt !== 16'h0001 || b_dpc !== 1'b1) begin
      errors++; $display("FAIL wrap_count: cnt=%h dpc=%b, want 0001/1", b_cnt, b_dpc);
    end
    b_reset = 1'b0;
    #1;
    checks++;
    if (b_dpc !== 1'b0 || b_cnt !== 16'd0 || b_rise !== 1'b0) begin
      errors++; $display("FAIL async_reset: dpc=%b cnt=%0d rise=%b, want 0/0/0", b_dpc, b_cnt, b_rise);
    end
    b_run = 1'b0;
    b_reset = 1'b1;
  endtask

  initial begin
    a_reset = 1'b1; a_btn = 1'b1; a_run = 1'b0; a_div = 4'd0;
    b_reset = 1'b1; b_btn = 1'b1; b_run = 1'b0; b_div = 4'd0;
    #2;
    b_reset = 1'b0;
    test_reset;
    test_single_step;
    test_bounce;
    test_press_dropped;
    test_run;
    test_wrap_and_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
